// File: rtl/rvga_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store path.
// One transaction in flight; data wins ties until IF has waited STARVE_LIMIT grants.
module rvga_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall
);

    // state      | meaning
    // S_IDLE     | no transaction; arbitration happens on the next edge
    // S_GRANT_IF | instruction fetch read on the memory port, waiting for mem_ack
    // S_GRANT_D  | load or store on the memory port, waiting for mem_ack

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_GRANT_IF, S_GRANT_D} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             pick_d, pick_if;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pick_d    = 1'b0;
        pick_if   = 1'b0;
        case (state)
            S_IDLE: begin
                // Data wins unless IF has already been passed over LIMIT times
                pick_d  = d_req & (~if_req | (starve_cnt < LIMIT));
                pick_if = ~pick_d & if_req;
                if (pick_d)       state_nxt = S_GRANT_D;
                else if (pick_if) state_nxt = S_GRANT_IF;
            end
            S_GRANT_IF, S_GRANT_D: begin
                if (mem_ack) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            d_rdata    <= '0;
            d_valid    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            mem_req  <= (state_nxt != S_IDLE);
            if_valid <= (state == S_GRANT_IF) & mem_ack;
            d_valid  <= (state == S_GRANT_D) & mem_ack;

            if ((state == S_GRANT_IF) && mem_ack)
                if_rdata <= mem_rdata;
            // Stores complete with a pulse but leave the last load data intact
            if ((state == S_GRANT_D) && mem_ack && !mem_we)
                d_rdata <= mem_rdata;

            if (pick_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_we ? d_be : '1;
            end else if (pick_if) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= '1;
            end

            if (state == S_IDLE) begin
                if (!if_req || pick_if)
                    starve_cnt <= '0;
                else if (pick_d && (starve_cnt != LIMIT))
                    starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Directed bench for rvga_mem_arbiter: reset, IF read, tie-break, starvation,
// wait states, ack while idle and reset mid-grant.
module tb_rvga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    // Memory responder: acks after ack_delay grant cycles when auto_mem is set
    logic        auto_mem = 1'b1;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic [31:0] rdata_val = '0;

    rvga_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            mem_rdata = rdata_val;
            if (auto_mem) begin
                if (mem_req) begin
                    mem_ack = (wcnt == ack_delay);
                    wcnt    = mem_ack ? 0 : wcnt + 1;
                end else begin
                    mem_ack = 1'b0;
                    wcnt    = 0;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1;
        repeat (3) @(negedge clk);
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_cmp++;
        if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        n_cmp++;
        if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        n_cmp++;
        if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        n_cmp++;
        if (mem_be !== 4'h0) begin n_err++; $display("FAIL reset_mem_be got=%h exp=0", mem_be); end
        n_cmp++;
        if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
        n_cmp++;
        if (d_valid !== 1'b0) begin n_err++; $display("FAIL reset_d_valid got=%b exp=0", d_valid); end
        n_cmp++;
        if (if_rdata !== 32'h0) begin n_err++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata); end
        n_cmp++;
        if (d_rdata !== 32'h0) begin n_err++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL reset_stall got=%b exp=1", stall); end
        n_cmp++;
        if_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_release_idle got=%b exp=0", mem_req); end
        n_cmp++;
    endtask

    task automatic test_if_read();
        logic d_seen;
        d_seen = 1'b0;
        ack_delay = 0; rdata_val = 32'hDEADBEEF;
        if_addr = 32'h100; if_req = 1'b1;
        @(negedge clk);
        d_seen |= d_valid;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF)
        begin n_err++; $display("FAIL if_grant got req=%b addr=%h we=%b be=%h exp 1/100/0/f", mem_req, mem_addr, mem_we, mem_be); end
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL if_stall_wait got=%b exp=1", stall); end
        n_cmp++;
        @(negedge clk);
        d_seen |= d_valid;
        if (if_valid !== 1'b1 || if_rdata !== 32'hDEADBEEF)
        begin n_err++; $display("FAIL if_valid_data got valid=%b data=%h exp 1/deadbeef", if_valid, if_rdata); end
        n_cmp++;
        if (mem_req !== 1'b0 || stall !== 1'b0)
        begin n_err++; $display("FAIL if_done got req=%b stall=%b exp 0/0", mem_req, stall); end
        n_cmp++;
        if_req = 1'b0;
        @(negedge clk);
        d_seen |= d_valid;
        if (if_valid !== 1'b0 || mem_req !== 1'b0)
        begin n_err++; $display("FAIL if_single_pulse got valid=%b req=%b exp 0/0", if_valid, mem_req); end
        n_cmp++;
        if (d_seen !== 1'b0) begin n_err++; $display("FAIL if_no_d_valid got=%b exp=0", d_seen); end
        n_cmp++;
    endtask

    task automatic test_tie();
        ack_delay = 0; rdata_val = 32'h12345678;
        if_addr = 32'h104; if_req = 1'b1;
        d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h55; d_be = 4'b0001; d_req = 1'b1;
        @(negedge clk);
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'h55 || mem_be !== 4'b0001)
        begin n_err++; $display("FAIL tie_store_first got req=%b we=%b addr=%h wd=%h be=%b exp 1/1/2000/55/0001", mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
        n_cmp++;
        @(negedge clk);
        if (d_valid !== 1'b1 || d_rdata !== 32'h0)
        begin n_err++; $display("FAIL tie_store_done got valid=%b rdata=%h exp 1/0", d_valid, d_rdata); end
        n_cmp++;
        d_req = 1'b0;
        @(negedge clk);
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h104 || mem_be !== 4'hF)
        begin n_err++; $display("FAIL tie_if_second got req=%b we=%b addr=%h be=%h exp 1/0/104/f", mem_req, mem_we, mem_addr, mem_be); end
        n_cmp++;
        @(negedge clk);
        if (if_valid !== 1'b1 || if_rdata !== 32'h12345678)
        begin n_err++; $display("FAIL tie_if_done got valid=%b data=%h exp 1/12345678", if_valid, if_rdata); end
        n_cmp++;
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int g;
        logic [31:0] exp_addr;
        g = 0;
        ack_delay = 0; rdata_val = 32'h0BADF00D;
        d_we = 1'b0; d_addr = 32'h3000; if_addr = 32'h200;
        d_req = 1'b1; if_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k % 2 == 1) begin
                exp_addr = (g % 5 == 4) ? 32'h200 : 32'h3000;
                if (mem_req !== 1'b1 || mem_addr !== exp_addr)
                begin n_err++; $display("FAIL starve_grant%0d got req=%b addr=%h exp 1/%h", g, mem_req, mem_addr, exp_addr); end
                n_cmp++;
                g++;
            end else begin
                if (mem_req !== 1'b0)
                begin n_err++; $display("FAIL starve_bubble%0d got req=%b exp=0", k, mem_req); end
                n_cmp++;
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        if (d_rdata !== 32'h0BADF00D)
        begin n_err++; $display("FAIL starve_load_data got=%h exp=0badf00d", d_rdata); end
        n_cmp++;
    endtask

    task automatic test_wait_states();
        int pulses;
        pulses = 0;
        ack_delay = 5; rdata_val = 32'hFFFF0000;
        d_we = 1'b1; d_addr = 32'h4000; d_wdata = 32'hCAFEF00D; d_be = 4'b1100; d_req = 1'b1;
        @(negedge clk);
        d_addr = 32'h9999; d_wdata = 32'h1111;
        for (int k = 1; k <= 6; k++) begin
            if (mem_req !== 1'b1 || mem_addr !== 32'h4000 || mem_wdata !== 32'hCAFEF00D || mem_be !== 4'b1100)
            begin n_err++; $display("FAIL wait_stable%0d got req=%b addr=%h wd=%h be=%b", k, mem_req, mem_addr, mem_wdata, mem_be); end
            n_cmp++;
            if (stall !== 1'b1) begin n_err++; $display("FAIL wait_stall%0d got=%b exp=1", k, stall); end
            n_cmp++;
            if (d_valid) pulses++;
            @(negedge clk);
        end
        if (d_valid !== 1'b1 || mem_req !== 1'b0)
        begin n_err++; $display("FAIL wait_done got valid=%b req=%b exp 1/0", d_valid, mem_req); end
        n_cmp++;
        if (d_valid) pulses++;
        if (d_rdata !== 32'h0BADF00D)
        begin n_err++; $display("FAIL wait_store_keeps_rdata got=%h exp=0badf00d", d_rdata); end
        n_cmp++;
        d_req = 1'b0;
        @(negedge clk);
        if (d_valid) pulses++;
        if (pulses !== 1) begin n_err++; $display("FAIL wait_pulse_count got=%0d exp=1", pulses); end
        n_cmp++;
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL wait_idle got req=%b exp=0", mem_req); end
        n_cmp++;
    endtask

    task automatic test_idle_ack();
        auto_mem = 1'b0; mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        if (if_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0)
        begin n_err++; $display("FAIL idle_ack got ifv=%b dv=%b req=%b exp 0/0/0", if_valid, d_valid, mem_req); end
        n_cmp++;
        mem_ack = 1'b0; auto_mem = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_grant();
        ack_delay = 4; rdata_val = 32'h77777777;
        d_we = 1'b0; d_addr = 32'h5000; d_req = 1'b1;
        @(negedge clk);
        if (mem_req !== 1'b1 || mem_addr !== 32'h5000)
        begin n_err++; $display("FAIL rmid_grant got req=%b addr=%h exp 1/5000", mem_req, mem_addr); end
        n_cmp++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        if (mem_req !== 1'b0 || d_valid !== 1'b0 || d_rdata !== 32'h0)
        begin n_err++; $display("FAIL rmid_abandon got req=%b dv=%b rdata=%h exp 0/0/0", mem_req, d_valid, d_rdata); end
        n_cmp++;
        d_req = 1'b0;
        @(negedge clk);
        if (d_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_valid got=%b exp=0", d_valid); end
        n_cmp++;
        rst_n = 1'b1;
        ack_delay = 0; rdata_val = 32'h600D0001;
        d_addr = 32'h5004; d_req = 1'b1;
        @(negedge clk);
        if (mem_req !== 1'b1 || mem_addr !== 32'h5004)
        begin n_err++; $display("FAIL rmid_fresh_grant got req=%b addr=%h exp 1/5004", mem_req, mem_addr); end
        n_cmp++;
        @(negedge clk);
        if (d_valid !== 1'b1 || d_rdata !== 32'h600D0001)
        begin n_err++; $display("FAIL rmid_fresh_done got dv=%b rdata=%h exp 1/600d0001", d_valid, d_rdata); end
        n_cmp++;
        d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_tie();
        test_starvation();
        test_wait_states();
        test_idle_ack();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
